output_acc_ram: RTL and testbench
=================================

Name: output_acc_ram

Overview:
- Parametrised successor to the layer output buffer: a simple dual-port RAM, one write port and one read port, for neuron outputs.
- Adds an accumulate write mode: saturating signed add into the stored word, used for partial-sum accumulation across input tiles.
- Adds a hardware clear sweep, a registered read with valid, and a sticky saturation flag.
- Sits between the MAC array (writer) and the next-layer input fetch or host readout (reader).

Parameters:
D_WIDTH, 16, data word width in bits, two's complement signed
A_WIDTH, 4, address width; DEPTH = 2**A_WIDTH words
CLR_ON_RST, 1, when 1 a clear sweep starts automatically after reset release

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  single-cycle pulse; starts a clear sweep
w_en  in  1  write request
w_acc  in  1  write mode: 0 overwrite, 1 saturating accumulate
w_addr  in  A_WIDTH  write address
data_in  in  D_WIDTH  write data
r_en  in  1  read request
r_addr  in  A_WIDTH  read address
data_out  out  D_WIDTH  registered read data
r_valid  out  1  data_out valid, one cycle after the accepted r_en
busy  out  1  clear sweep in progress
sat_flag  out  1  sticky: an accumulate saturated since the last clear or reset

Behaviour:
- Reset values (asynchronous on rst):
  - data_out=0, r_valid=0, sat_flag=0, sweep counter=0.
  - State=CLEAR if CLR_ON_RST=1, else READY; busy reflects that state.
  - RAM contents are not reset by rst.
- FSM has two states, CLEAR and READY:
  - CLEAR: writes 0 to word cnt each cycle and increments cnt. At cnt==DEPTH-1 the cycle writes the last word and moves to READY. The sweep takes exactly DEPTH cycles.
  - READY: clr=1 sets cnt=0, clears sat_flag and moves to CLEAR next cycle. clr asserted while in CLEAR restarts the sweep at cnt=0.
- busy = (state==CLEAR).
- During CLEAR:
  - w_en and r_en are ignored (dropped, not queued).
  - r_valid is 0 the next cycle and data_out holds its value.
- Write in READY with w_en=1 at posedge:
  - w_acc=0: RAM[w_addr] <= data_in.
  - w_acc=1: RAM[w_addr] <= sat(RAM[w_addr] + data_in). Compute the sum in D_WIDTH+1 bits. Clamp to max 2**(D_WIDTH-1)-1 or min -2**(D_WIDTH-1) on overflow and set sat_flag.
  - Single-cycle read-modify-write using an asynchronous internal read. Back-to-back accumulates to the same address are therefore hazard-free.
- Read in READY with r_en=1 at posedge:
  - The next cycle gives data_out = RAM[r_addr] as it was before that edge's write, and r_valid=1.
  - r_en=0 gives r_valid=0 and data_out holds.
- Read and write to the same address in the same cycle: the read returns the old (pre-write) value. Verification must check this explicitly.
- sat_flag is cleared only by rst or by clr acceptance. It stays set across later non-saturating writes.
- Address wrap: addresses are exactly A_WIDTH bits, so no out-of-range case exists.
- Reset mid-sweep aborts the sweep. With CLR_ON_RST=1 the sweep restarts from 0 after rst release.

Decomposition:
- Shared package output_ram_pkg:
  - FSM state enum (ST_CLEAR, ST_READY).
  - Function sat_add(a, b) returning the clamped sum and an overflow bit, parametrised through D_WIDTH.
- One sub-module, output_acc_ram_core: the storage array with one synchronous write port, an asynchronous read for accumulate, and a registered read port.
- The top level holds the FSM, the sweep mux onto the write port, the saturation logic and sat_flag.

Test Plan (D_WIDTH=16, A_WIDTH=4):
- Reset then idle: busy=1 for exactly 16 cycles after rst release, then 0. Reads of all 16 addresses return 0 with r_valid=1 one cycle after each r_en.
- Overwrite, then read: write 0x1234 to addr 5, then r_en addr 5. Next cycle data_out=0x1234, r_valid=1, and r_valid drops when r_en=0.
- Accumulate back-to-back:
  - Writes 100, -30, 7 with w_acc=1 to addr 3 on consecutive cycles, then read: data_out=77, sat_flag=0.
  - Write 0x7FF0, then accumulate 0x0020 at addr 9: read gives 0x7FFF, sat_flag=1.
  - Accumulate 0x8000 + (-1) at addr 10: result 0x8000.
- Same-cycle read and write: with addr 2 holding 11, write 22 and read addr 2 in the same cycle. data_out=11; the next read gives 22.
- clr mid-traffic:
  - With addr 4=55 and sat_flag=1, pulse clr while also driving w_en. busy goes high for 16 cycles, the write is dropped, sat_flag=0, and all words read back 0.
  - clr re-pulsed at sweep cycle 8 extends busy to 8+16 cycles total.
- Async reset mid-sweep: assert rst at sweep cycle 6, asynchronously (off the clock edge). r_valid and data_out go 0 immediately, and after release busy lasts a full 16 cycles.

Source files
------------

// File: rtl/output_ram_pkg.sv
// Shared types and arithmetic for the accumulating output RAM.
package output_ram_pkg;

   // Controller states: CLEAR sweeps zeros through the array, READY serves traffic.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Widest data word sat_add can handle; callers sign-extend into this width.
   localparam int SAT_MAX_W = 64;

   // Signed add clamped to a 'width'-bit two's complement range.
   // Operands must already be sign-extended from 'width' bits to SAT_MAX_W bits.
   // Returns {overflow, clamped_sum}; only the low 'width' bits of the sum matter.
   function automatic logic [SAT_MAX_W:0] sat_add(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input int                          width
   );
      logic signed [SAT_MAX_W:0] one;
      logic signed [SAT_MAX_W:0] max_v;
      logic signed [SAT_MAX_W:0] min_v;
      logic signed [SAT_MAX_W:0] sum;
      logic [SAT_MAX_W-1:0]      res;
      logic                      ovf;
      one   = {{SAT_MAX_W{1'b0}}, 1'b1};
      max_v = (one <<< (width - 1)) - one;
      min_v = ~max_v;
      // One extra bit of headroom so the raw sum can never wrap.
      sum   = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
      if (sum > max_v) begin
         ovf = 1'b1;
         res = max_v[SAT_MAX_W-1:0];
      end else if (sum < min_v) begin
         ovf = 1'b1;
         res = min_v[SAT_MAX_W-1:0];
      end else begin
         ovf = 1'b0;
         res = sum[SAT_MAX_W-1:0];
      end
      return {ovf, res};
   endfunction

endpackage

// File: rtl/output_acc_ram_if.sv
// Bus between the MAC-array writer / next-layer reader and the output RAM.
interface output_acc_ram_if #(
   parameter int D_WIDTH = 16,
   parameter int A_WIDTH = 4
);
   logic               clr;
   logic               w_en;
   logic               w_acc;
   logic [A_WIDTH-1:0] w_addr;
   logic [D_WIDTH-1:0] data_in;
   logic               r_en;
   logic [A_WIDTH-1:0] r_addr;
   logic [D_WIDTH-1:0] data_out;
   logic               r_valid;
   logic               busy;
   logic               sat_flag;

   // Client side: issues writes, reads and clears.
   modport master (
      output clr, w_en, w_acc, w_addr, data_in, r_en, r_addr,
      input  data_out, r_valid, busy, sat_flag
   );

   // RAM side.
   modport slave (
      input  clr, w_en, w_acc, w_addr, data_in, r_en, r_addr,
      output data_out, r_valid, busy, sat_flag
   );
endinterface

// File: rtl/output_acc_ram_core.sv
// Storage array: one synchronous write port, a combinational peek at the write
// address (for read-modify-write), and a registered read port with valid.
module output_acc_ram_core #(
   parameter int D_WIDTH = 16,
   parameter int A_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [A_WIDTH-1:0] waddr_i,
   input  logic [D_WIDTH-1:0] wdata_i,
   output logic [D_WIDTH-1:0] wold_o,
   input  logic               re_i,
   input  logic [A_WIDTH-1:0] raddr_i,
   output logic [D_WIDTH-1:0] rdata_o,
   output logic               rvalid_o
);
   logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
   logic [D_WIDTH-1:0] rdata_q;
   logic               rvalid_q;

   // Current contents at the write address, so accumulate sees this cycle's value.
   assign wold_o = mem_q[waddr_i];

   // Array write; contents are deliberately left untouched by rst.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read: samples the array before this edge's write lands, so a
   // same-address read/write returns the old word. data_out holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= re_i;
         if (re_i) begin
            rdata_q <= mem_q[raddr_i];
         end
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
endmodule

// File: rtl/output_acc_ram.sv
// Neuron output buffer with saturating accumulate writes, a hardware clear
// sweep and a sticky saturation flag.
module output_acc_ram
   import output_ram_pkg::*;
#(
   parameter int D_WIDTH    = 16,
   parameter int A_WIDTH    = 4,
   parameter bit CLR_ON_RST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   output_acc_ram_if.slave      bus
);
   localparam state_e RST_STATE = CLR_ON_RST ? ST_CLEAR : ST_READY;
   localparam logic [A_WIDTH-1:0] LAST_ADDR = {A_WIDTH{1'b1}};

   state_e             state_q, state_d;
   logic [A_WIDTH-1:0] cnt_q, cnt_d;
   logic               sat_q, sat_d;

   logic               ram_we;
   logic [A_WIDTH-1:0] ram_waddr;
   logic [D_WIDTH-1:0] ram_wdata;
   logic               ram_re;
   logic [D_WIDTH-1:0] ram_wold;

   logic [SAT_MAX_W:0] sat_res;
   logic [D_WIDTH-1:0] acc_sum;
   logic               acc_ovf;
   logic               unused_sat_hi;

   // Saturating sum of the stored word and the incoming partial sum.
   assign sat_res       = sat_add(SAT_MAX_W'(signed'(ram_wold)),
                                  SAT_MAX_W'(signed'(bus.data_in)), D_WIDTH);
   assign acc_ovf       = sat_res[SAT_MAX_W];
   assign acc_sum       = sat_res[D_WIDTH-1:0];
   assign unused_sat_hi = ^sat_res[SAT_MAX_W-1:D_WIDTH];

   // Next state, sweep counter, write-port mux and saturation flag update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      ram_we    = 1'b0;
      ram_waddr = bus.w_addr;
      ram_wdata = bus.data_in;
      ram_re    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            // Sweep owns the write port; client writes and reads are dropped.
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
            if (bus.clr) begin
               cnt_d = '0;
               sat_d = 1'b0;
            end else if (cnt_q == LAST_ADDR) begin
               cnt_d   = '0;
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + A_WIDTH'(1);
            end
         end
         ST_READY: begin
            ram_re = bus.r_en;
            if (bus.clr) begin
               // Clear wins over a simultaneous write, which is discarded.
               state_d = ST_CLEAR;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end else begin
               ram_we    = bus.w_en;
               ram_wdata = bus.w_acc ? acc_sum : bus.data_in;
               if (bus.w_en && bus.w_acc && acc_ovf) begin
                  sat_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = RST_STATE;
         end
      endcase
   end

   // Controller registers; rst aborts any sweep in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.busy     = (state_q == ST_CLEAR);
   assign bus.sat_flag = sat_q;

   output_acc_ram_core #(
      .D_WIDTH (D_WIDTH),
      .A_WIDTH (A_WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .we_i     (ram_we),
      .waddr_i  (ram_waddr),
      .wdata_i  (ram_wdata),
      .wold_o   (ram_wold),
      .re_i     (ram_re),
      .raddr_i  (bus.r_addr),
      .rdata_o  (bus.data_out),
      .rvalid_o (bus.r_valid)
   );
endmodule

// File: tb/tb_output_acc_ram.sv
// Self-checking bench for output_acc_ram (D_WIDTH=16, A_WIDTH=4, CLR_ON_RST=1).
module tb_output_acc_ram;
   logic clk = 1'b0;
   logic rst = 1'b1;

   output_acc_ram_if #(.D_WIDTH(16), .A_WIDTH(4)) bus ();

   output_acc_ram #(.D_WIDTH(16), .A_WIDTH(4), .CLR_ON_RST(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain array of words plus the observable read state.
   logic [15:0] mem_m [16];
   logic        sat_m;
   logic [15:0] last_data_m;
   logic        exp_valid_m;

   typedef struct {
      logic        we;
      logic        acc;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        re;
      logic [3:0]  ra;
      logic        ev;
      logic        cd;
      logic [15:0] ed;
      logic        es;
   } vec_t;
   vec_t tbl [20];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.clr = 1'b0; bus.w_en = 1'b0; bus.w_acc = 1'b0; bus.w_addr = '0;
      bus.data_in = '0; bus.r_en = 1'b0; bus.r_addr = '0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      sat_m = 1'b0;
   endtask

   // One READY-state transaction: drive, clock, update model, sample at +1.
   task automatic cycle(input logic we, input logic acc, input logic [3:0] wa,
                        input logic [15:0] wd, input logic re, input logic [3:0] ra);
      int s;
      bus.w_en = we; bus.w_acc = acc; bus.w_addr = wa; bus.data_in = wd;
      bus.r_en = re; bus.r_addr = ra;
      @(posedge clk);
      exp_valid_m = re;
      if (re) last_data_m = mem_m[ra];
      if (we) begin
         if (acc) begin
            s = int'($signed(mem_m[wa])) + int'($signed(wd));
            if (s > 32767) begin s = 32767; sat_m = 1'b1; end
            else if (s < -32768) begin s = -32768; sat_m = 1'b1; end
            mem_m[wa] = 16'(s);
         end else begin
            mem_m[wa] = wd;
         end
      end
      #1;
      idle_inputs();
      $display("txn we=%0b acc=%0b wa=%0d wd=%h re=%0b ra=%0d -> r_valid=%0b data_out=%h sat=%0b",
               we, acc, wa, wd, re, ra, bus.r_valid, bus.data_out, bus.sat_flag);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_pulse(input logic we, input logic [3:0] wa, input logic [15:0] wd);
      bus.clr = 1'b1; bus.w_en = we; bus.w_addr = wa; bus.data_in = wd;
      @(posedge clk);
      #1;
      idle_inputs();
      model_clear();
      exp_valid_m = 1'b0;
      $display("txn clr w_en=%0b -> busy=%0b sat=%0b", we, bus.busy, bus.sat_flag);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 0; a < 16; a++) begin
         cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(a));
         chk({tag, "_rvalid"}, {31'd0, bus.r_valid}, 32'd1);
         chk({tag, "_rdata"}, {16'd0, bus.data_out}, 32'd0);
      end
      cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0);
      chk({tag, "_rvalid_drop"}, {31'd0, bus.r_valid}, 32'd0);
   endtask

   initial begin
      int n;
      int total;
      logic        we, acc, re;
      logic [3:0]  wa, ra;
      logic [15:0] wd;

      tbl[0]  = '{1'b1, 1'b0, 4'd5,  16'h1234, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b1, 1'b1, 16'h1234, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1234, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 4'd3,  16'd100,  1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 4'd3,  16'hFFE2, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 4'd3,  16'd7,    1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 1'b1, 16'd77,   1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'd9,  16'h7FF0, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 4'd9,  16'h0020, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd9,  1'b1, 1'b1, 16'h7FFF, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 4'd10, 16'h8000, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 4'd10, 16'hFFFF, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd10, 1'b1, 1'b1, 16'h8000, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 4'd2,  16'd11,   1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 4'd2,  16'd22,   1'b1, 4'd2,  1'b1, 1'b1, 16'd11,   1'b1};
      tbl[15] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd2,  1'b1, 1'b1, 16'd22,   1'b1};
      tbl[16] = '{1'b1, 1'b1, 4'd3,  16'hFFB3, 1'b1, 4'd3,  1'b1, 1'b1, 16'd77,   1'b1};
      tbl[17] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 1'b1, 16'h0000, 1'b1};
      tbl[18] = '{1'b1, 1'b1, 4'd10, 16'h8000, 1'b0, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd10, 1'b1, 1'b1, 16'h8000, 1'b1};

      idle_inputs();
      model_clear();
      last_data_m = '0;
      exp_valid_m = 1'b0;

      // Reset state, then the automatic post-reset sweep.
      repeat (2) @(posedge clk);
      #3;
      chk("rst_data_out", {16'd0, bus.data_out}, 32'd0);
      chk("rst_r_valid", {31'd0, bus.r_valid}, 32'd0);
      chk("rst_sat", {31'd0, bus.sat_flag}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b0;
      count_busy(n);
      chk("init_sweep_len", n, 32'd16);
      read_all_zero("init_read");

      // Directed vectors.
      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].we, tbl[i].acc, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
         chk($sformatf("vec%0d_rvalid", i), {31'd0, bus.r_valid}, {31'd0, tbl[i].ev});
         chk($sformatf("vec%0d_sat", i), {31'd0, bus.sat_flag}, {31'd0, tbl[i].es});
         if (tbl[i].cd) chk($sformatf("vec%0d_data", i), {16'd0, bus.data_out}, {16'd0, tbl[i].ed});
      end

      // Randomised READY traffic against the model.
      for (int i = 0; i < 300; i++) begin
         we  = 1'($urandom_range(0, 1));
         acc = 1'($urandom_range(0, 1));
         wa  = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       wd = 16'h7F00 + 16'($urandom_range(0, 255));
            1:       wd = 16'h8000 + 16'($urandom_range(0, 255));
            default: wd = 16'($urandom);
         endcase
         re  = 1'($urandom_range(0, 1));
         ra  = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom_range(0, 15));
         cycle(we, acc, wa, wd, re, ra);
         chk($sformatf("rnd%0d_rvalid", i), {31'd0, bus.r_valid}, {31'd0, exp_valid_m});
         chk($sformatf("rnd%0d_data", i), {16'd0, bus.data_out}, {16'd0, last_data_m});
         chk($sformatf("rnd%0d_sat", i), {31'd0, bus.sat_flag}, {31'd0, sat_m});
      end

      // clr with a concurrent write: write dropped, sat cleared, full sweep.
      cycle(1'b1, 1'b1, 4'd9, 16'h7FFF, 1'b0, 4'd0);
      cycle(1'b1, 1'b0, 4'd4, 16'd55, 1'b0, 4'd0);
      chk("clrA_sat_before", {31'd0, bus.sat_flag}, 32'd1);
      clr_pulse(1'b1, 4'd4, 16'h0777);
      chk("clrA_busy", {31'd0, bus.busy}, 32'd1);
      chk("clrA_sat", {31'd0, bus.sat_flag}, 32'd0);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         if (n == 10) begin
            bus.w_en = 1'b1; bus.w_addr = 4'd0; bus.data_in = 16'h0BAD;
            bus.r_en = 1'b1; bus.r_addr = 4'd4;
         end
         @(posedge clk);
         #1;
         idle_inputs();
         if (n == 10) begin
            chk("clrA_read_dropped", {31'd0, bus.r_valid}, 32'd0);
            chk("clrA_data_hold", {16'd0, bus.data_out}, {16'd0, last_data_m});
         end
         n++;
      end
      chk("clrA_sweep_len", n, 32'd16);
      read_all_zero("clrA_read");

      // clr re-pulsed during the 8th sweep cycle restarts the sweep.
      clr_pulse(1'b0, 4'd0, 16'd0);
      total = 0;
      repeat (7) idle_cycle();
      total += 7;
      chk("clrB_busy_mid", {31'd0, bus.busy}, 32'd1);
      clr_pulse(1'b0, 4'd0, 16'd0);
      total += 1;
      count_busy(n);
      total += n;
      chk("clrB_total_busy", total, 32'd24);

      // Asynchronous reset in the middle of a sweep.
      cycle(1'b1, 1'b0, 4'd1, 16'h55AA, 1'b0, 4'd0);
      cycle(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd1);
      chk("rstC_pre_data", {16'd0, bus.data_out}, 32'h55AA);
      clr_pulse(1'b0, 4'd0, 16'd0);
      repeat (5) idle_cycle();
      #2;
      rst = 1'b1;
      #1;
      chk("rstC_data_out", {16'd0, bus.data_out}, 32'd0);
      chk("rstC_r_valid", {31'd0, bus.r_valid}, 32'd0);
      chk("rstC_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_clear();
      last_data_m = '0;
      count_busy(n);
      chk("rstC_sweep_len", n, 32'd16);
      read_all_zero("rstC_read");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
